// File: rtl/sha256_compress_engine.sv
// sha256_compress_engine
//   SHA-256 compression of one 512-bit block. The engine keeps the working
//   variables a..h, a 16-word sliding message-schedule window and the round
//   constant table internally, and computes UNROLL rounds per clock.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake for h_in and block_in
//   h_in [255:0]        : chaining value, [255:224]=H0 (a) .. [31:0]=H7 (h)
//   block_in [511:0]    : message block, [511:480]=W0 .. [31:0]=W15
//   out_valid/out_ready : output handshake, digest held while out_valid
//   digest [255:0]      : result, same word order as h_in
//   busy                : high while rounds or the final addition are running
module sha256_compress_engine #(
  parameter int UNROLL    = 1,
  parameter bit FINAL_ADD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] h_in,
  input  logic [511:0] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_compress_engine: UNROLL must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, OUT = 2'd3} state_t;

  localparam logic [31:0] K_C [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  state_t      state_r, state_next_s;
  logic [5:0]  t_r;
  logic [31:0] hv_r    [0:7];   // a..h
  logic [31:0] hcopy_r [0:7];   // chaining value kept for the final addition
  logic [31:0] w_r     [0:15];  // w_r[0] is W[t] for the next round
  logic        in_ready_r, out_valid_r, busy_r;
  logic [255:0] digest_r;

  // Round chain: stage i of these arrays holds the state after i rounds this cycle.
  logic [31:0] st_s  [0:UNROLL][0:7];
  logic [31:0] win_s [0:UNROLL][0:15];
  logic [31:0] t1_s  [0:UNROLL-1];
  logic [31:0] t2_s  [0:UNROLL-1];
  logic        last_round_s;

  // The cycle whose last round is 63 ends the ROUND phase.
  assign last_round_s = (({1'b0, t_r} + 7'(UNROLL)) == 7'd64);

  // Combinational UNROLL-deep round chain including the window update.
  always_comb begin
    for (int k = 0; k <= UNROLL; k++) begin
      for (int j = 0; j < 8; j++) st_s[k][j] = 32'd0;
      for (int j = 0; j < 16; j++) win_s[k][j] = 32'd0;
    end
    for (int k = 0; k < UNROLL; k++) begin
      t1_s[k] = 32'd0;
      t2_s[k] = 32'd0;
    end
    for (int j = 0; j < 8; j++) st_s[0][j] = hv_r[j];
    for (int j = 0; j < 16; j++) win_s[0][j] = w_r[j];
    for (int i = 0; i < UNROLL; i++) begin
      t1_s[i] = st_s[i][7] + big_s1(st_s[i][4])
              + ((st_s[i][4] & st_s[i][5]) ^ (~st_s[i][4] & st_s[i][6]))
              + K_C[t_r + 6'(i)] + win_s[i][0];
      t2_s[i] = big_s0(st_s[i][0])
              + ((st_s[i][0] & st_s[i][1]) ^ (st_s[i][0] & st_s[i][2]) ^ (st_s[i][1] & st_s[i][2]));
      st_s[i+1][0] = t1_s[i] + t2_s[i];
      st_s[i+1][1] = st_s[i][0];
      st_s[i+1][2] = st_s[i][1];
      st_s[i+1][3] = st_s[i][2];
      st_s[i+1][4] = st_s[i][3] + t1_s[i];
      st_s[i+1][5] = st_s[i][4];
      st_s[i+1][6] = st_s[i][5];
      st_s[i+1][7] = st_s[i][6];
      // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]; computed even while
      // t<16 so the window is always 16 words ahead of consumption.
      for (int j = 0; j < 15; j++) win_s[i+1][j] = win_s[i][j+1];
      win_s[i+1][15] = small_s1(win_s[i][14]) + win_s[i][9] + small_s0(win_s[i][1]) + win_s[i][0];
    end
  end

  // Next-state logic for IDLE -> ROUND -> FINAL -> OUT -> IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_next_s = ROUND; else state_next_s = IDLE;
      ROUND:   if (last_round_s) state_next_s = FINAL; else state_next_s = ROUND;
      FINAL:   state_next_s = OUT;
      OUT:     if (out_ready) state_next_s = IDLE; else state_next_s = OUT;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Datapath: block load, round updates and final digest formation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r      <= 6'd0;
      digest_r <= 256'd0;
      for (int j = 0; j < 8; j++) begin
        hv_r[j]    <= 32'd0;
        hcopy_r[j] <= 32'd0;
      end
      for (int j = 0; j < 16; j++) w_r[j] <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            t_r <= 6'd0;
            for (int j = 0; j < 8; j++) begin
              hv_r[j]    <= h_in[255-32*j -: 32];
              hcopy_r[j] <= h_in[255-32*j -: 32];
            end
            for (int j = 0; j < 16; j++) w_r[j] <= block_in[511-32*j -: 32];
          end
        end
        ROUND: begin
          t_r <= t_r + 6'(UNROLL);
          for (int j = 0; j < 8; j++) hv_r[j] <= st_s[UNROLL][j];
          for (int j = 0; j < 16; j++) w_r[j] <= win_s[UNROLL][j];
        end
        FINAL: begin
          for (int j = 0; j < 8; j++) begin
            if (FINAL_ADD) digest_r[255-32*j -: 32] <= hcopy_r[j] + hv_r[j];
            else           digest_r[255-32*j -: 32] <= hv_r[j];
          end
        end
        default: begin
          t_r <= t_r;
        end
      endcase
    end
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == OUT);
      busy_r      <= (state_next_s == ROUND) || (state_next_s == FINAL);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign digest    = digest_r;

endmodule

// File: tb/tb_sha256_compress_engine.sv
module tb_sha256_compress_engine;

  localparam int NI = 5;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] B1_BLK = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2_BLK = {480'd0, 32'h000001c0};

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Instances 0..3: UNROLL 1,2,4,8 with final add; instance 4: UNROLL 4 raw a..h.
  int lat_exp [NI] = '{65, 33, 17, 9, 17};
  bit fa      [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [255:0] h_in;
  logic [511:0] block_in;
  logic         ir [NI];
  logic         ov [NI];
  logic         bz [NI];
  logic [255:0] dg [NI];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_compress_engine #(.UNROLL(1 << g), .FINAL_ADD(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .h_in(h_in), .block_in(block_in), .out_valid(ov[g]), .out_ready(out_ready),
      .digest(dg[g]), .busy(bz[g])
    );
  end

  sha256_compress_engine #(.UNROLL(4), .FINAL_ADD(1'b0)) u_dut_raw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
    .h_in(h_in), .block_in(block_in), .out_valid(ov[4]), .out_ready(out_ready),
    .digest(dg[4]), .busy(bz[4])
  );

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straightforward FIPS 180-4 compression with the full 64-word schedule.
  function automatic logic [255:0] sha_ref(input logic [255:0] h, input logic [511:0] blk, input bit add);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int j = 0; j < 8; j++) v[j] = h[255-32*j -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = add ? v[j] + h[255-32*j -: 32] : v[j];
    return r;
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = a[32*j +: 32] + b[32*j +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Present one block; the following rising edge is the accept edge.
  task automatic send(input logic [255:0] h, input logic [511:0] blk);
    @(negedge clk);
    h_in = h; block_in = blk; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; h_in = rand256(); block_in = rand512();
    check_value("in_ready_low_after_accept", {255'd0, ir[0]}, 256'd0);
  endtask

  // Wait for every instance's result after an accept edge, check latency and digest.
  task automatic collect(input logic [255:0] h, input logic [511:0] blk,
                         output logic [255:0] d0, output logic [255:0] draw);
    bit seen [NI];
    bit all_s;
    int c;
    logic [255:0] e_add, e_raw;
    e_add = sha_ref(h, blk, 1'b1);
    e_raw = sha_ref(h, blk, 1'b0);
    for (int k = 0; k < NI; k++) seen[k] = 1'b0;
    d0 = '0; draw = '0; c = 0; all_s = 1'b0;
    while (!all_s && c < 100) begin
      @(posedge clk); #1; c++;
      if (c == 1) check_value("busy_in_round", {255'd0, bz[0]}, 256'd1);
      all_s = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (!seen[k] && ov[k]) begin
          seen[k] = 1'b1;
          check_value($sformatf("latency_inst%0d", k), c, lat_exp[k]);
          check_value($sformatf("digest_inst%0d", k), dg[k], fa[k] ? e_add : e_raw);
          if (k == 0) d0 = dg[k];
          if (k == 4) draw = dg[k];
        end
        all_s = all_s & seen[k];
      end
    end
    for (int k = 0; k < NI; k++)
      if (!seen[k]) check_value($sformatf("timeout_inst%0d", k), {255'd0, seen[k]}, 256'd1);
    c = 0; all_s = 1'b0;
    while (!all_s && c < 10) begin
      @(posedge clk); #1; c++;
      all_s = 1'b1;
      for (int k = 0; k < NI; k++) all_s = all_s & ir[k];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < NI; k++) begin
      check_value($sformatf("%s_in_ready%0d", tag, k), {255'd0, ir[k]}, 256'd1);
      check_value($sformatf("%s_out_valid%0d", tag, k), {255'd0, ov[k]}, 256'd0);
      check_value($sformatf("%s_busy%0d", tag, k), {255'd0, bz[k]}, 256'd0);
      check_value($sformatf("%s_digest%0d", tag, k), dg[k], 256'd0);
    end
  endtask

  initial begin
    logic [255:0] d0, draw, d1, ha, hb;
    logic [511:0] ba, bb;
    logic [255:0] snap [NI];
    int c;
    bit all_s;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; h_in = '0; block_in = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // "abc" with FIPS IV on every UNROLL, plus raw-mode relation.
    send(IV, ABC_BLK);
    collect(IV, ABC_BLK, d0, draw);
    check_value("abc_digest", d0, ABC_DIG);
    check_value("abc_raw_plus_iv", add_words(draw, IV), ABC_DIG);

    // Two-block message, first digest chained into the second block.
    send(IV, B1_BLK);
    collect(IV, B1_BLK, d1, draw);
    send(d1, B2_BLK);
    collect(d1, B2_BLK, d0, draw);
    check_value("two_block_digest", d0, TWO_DIG);

    // Random chaining values and blocks.
    for (int n = 0; n < 3; n++) begin
      ha = rand256(); ba = rand512();
      send(ha, ba);
      collect(ha, ba, d0, draw);
    end

    // Backpressure: output held, new input ignored until the out handshake.
    ha = rand256(); ba = rand512(); hb = rand256(); bb = rand512();
    out_ready = 1'b0;
    send(ha, ba);
    c = 0; all_s = 1'b0;
    while (!all_s && c < 100) begin
      @(posedge clk); #1; c++;
      all_s = 1'b1;
      for (int k = 0; k < NI; k++) all_s = all_s & ov[k];
    end
    check_value("bp_all_valid", {255'd0, all_s}, 256'd1);
    for (int k = 0; k < NI; k++) begin
      snap[k] = dg[k];
      check_value($sformatf("bp_digest%0d", k), dg[k], sha_ref(ha, ba, fa[k]));
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      in_valid = 1'($urandom); h_in = rand256(); block_in = rand512();
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        check_value($sformatf("bp_stable%0d", k), dg[k], snap[k]);
        check_value($sformatf("bp_in_ready%0d", k), {255'd0, ir[k]}, 256'd0);
        check_value($sformatf("bp_out_valid%0d", k), {255'd0, ov[k]}, 256'd1);
      end
    end
    @(negedge clk);
    in_valid = 1'b1; h_in = hb; block_in = bb; out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("bp_handshake_out_valid", {255'd0, ov[0]}, 256'd0);
    check_value("bp_handshake_in_ready", {255'd0, ir[0]}, 256'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; h_in = rand256(); block_in = rand512();
    collect(hb, bb, d0, draw);

    // Reset during round 30, then rerun "abc".
    send(IV, ABC_BLK);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    send(IV, ABC_BLK);
    collect(IV, ABC_BLK, d0, draw);
    check_value("rerun_abc_digest", d0, ABC_DIG);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
